// File: rtl/falafel_mem_arbiter.sv
// falafel_mem_arbiter
//
// Round-robin arbiter sharing the single falafel memory port between
// NUM_REQ requesters (index 0 is the allocator core). One request per cycle
// is forwarded to the memory request channel. The requester index of every
// accepted read is pushed into an in-order tag FIFO so that in-order memory
// responses can be routed back to the requester that issued them.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_val_i/req_rdy_o     per-requester request handshake
//   req_is_write_i          per-requester write flag (1 = write)
//   req_addr_i/req_data_i   packed address / write data, DATA_W per requester
//   rsp_val_o/rsp_rdy_i     per-requester read response handshake
//   rsp_data_o              response data shared by all requesters
//   mem_req_*               memory request channel
//   mem_rsp_*               memory response channel (reads only, in order)
//   outstanding_o           reads in flight
//   err_o                   sticky: response arrived with no read outstanding
module falafel_mem_arbiter #(
    parameter int DATA_W          = 64,
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_val_i,
    output logic [NUM_REQ-1:0]                   req_rdy_o,
    input  logic [NUM_REQ-1:0]                   req_is_write_i,
    input  logic [NUM_REQ*DATA_W-1:0]            req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]            req_data_i,
    output logic [NUM_REQ-1:0]                   rsp_val_o,
    input  logic [NUM_REQ-1:0]                   rsp_rdy_i,
    output logic [DATA_W-1:0]                    rsp_data_o,
    output logic                                 mem_req_val_o,
    input  logic                                 mem_req_rdy_i,
    output logic                                 mem_req_is_write_o,
    output logic [DATA_W-1:0]                    mem_req_addr_o,
    output logic [DATA_W-1:0]                    mem_req_data_o,
    input  logic                                 mem_rsp_val_i,
    output logic                                 mem_rsp_rdy_o,
    input  logic [DATA_W-1:0]                    mem_rsp_data_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        OPEN,
        LOCKED
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_idx;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   head;
    logic               found;
    logic [NUM_REQ-1:0] eligible;
    logic               req_valid;
    logic               req_fire;

    logic [IDX_W-1:0]   tags [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               stray;

    assign full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count == '0);

    // Reads need a free tag slot; the registered full flag is used, so a pop
    // in the same cycle does not free a slot for a new read.
    assign eligible = req_val_i & (req_is_write_i | {NUM_REQ{~full}});

    // First eligible index scanning upward from rr_ptr+1, wrapping around.
    always_comb begin
        pick  = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign sel       = (state == LOCKED) ? lock_idx : pick;
    assign req_valid = (state == LOCKED) ? req_val_i[lock_idx] : (|eligible);

    assign mem_req_val_o      = req_valid & ~rst_i;
    assign mem_req_is_write_o = req_is_write_i[sel];
    assign mem_req_addr_o     = req_addr_i[sel*DATA_W +: DATA_W];
    assign mem_req_data_o     = req_data_i[sel*DATA_W +: DATA_W];

    assign req_fire = mem_req_val_o & mem_req_rdy_i;
    assign push     = req_fire & ~mem_req_is_write_o;

    always_comb begin
        req_rdy_o      = '0;
        req_rdy_o[sel] = req_fire;
    end

    // Response routing follows the oldest outstanding tag.
    assign head = tags[rd_ptr];

    always_comb begin
        rsp_val_o       = '0;
        rsp_val_o[head] = mem_rsp_val_i & ~empty & ~rst_i;
    end

    assign rsp_data_o = mem_rsp_data_i;

    // With no read outstanding the response is accepted and dropped so a
    // stray beat cannot stall the memory response channel.
    assign mem_rsp_rdy_o = ~rst_i & (empty ? 1'b1 : rsp_rdy_i[head]);
    assign pop           = mem_rsp_val_i & mem_rsp_rdy_o & ~empty;
    assign stray         = mem_rsp_val_i & empty;

    // Grant FSM and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= OPEN;
            lock_idx <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                OPEN: begin
                    if (mem_req_val_o && !mem_req_rdy_i) begin
                        state    <= LOCKED;
                        lock_idx <= pick;
                    end
                end
                LOCKED: begin
                    if (req_fire) begin
                        state <= OPEN;
                    end
                end
                default: state <= OPEN;
            endcase
            if (req_fire) begin
                rr_ptr <= sel;
            end
        end
    end

    // Tag storage holds no control state, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tags[wr_ptr] <= sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (stray) begin
                err_o <= 1'b1;
            end
        end
    end

    assign outstanding_o = count;

    // A locked requester must keep valid asserted until it is accepted.
    a_locked_valid_held: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state == LOCKED) |-> req_val_i[lock_idx]
    );

    a_count_bounded: assert property (
        @(posedge clk_i) disable iff (rst_i)
        count <= CNT_W'(MAX_OUTSTANDING)
    );

endmodule

// File: tb/tb_falafel_mem_arbiter.sv
// tb_falafel_mem_arbiter
//
// Directed self-checking bench for falafel_mem_arbiter with two requesters,
// 64-bit data and a 4-entry tag FIFO. Inputs change just after the falling
// clock edge and outputs are checked 2 ns later, well away from the rising
// edge.
module tb_falafel_mem_arbiter;

    localparam int DATA_W  = 64;
    localparam int NUM_REQ = 2;
    localparam int MAX_OUT = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_val;
    logic [NUM_REQ-1:0]    req_rdy;
    logic [NUM_REQ-1:0]    req_is_write;
    logic [2*DATA_W-1:0]   req_addr;
    logic [2*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]    rsp_val;
    logic [NUM_REQ-1:0]    rsp_rdy;
    logic [DATA_W-1:0]     rsp_data;
    logic                  mem_req_val;
    logic                  mem_req_rdy;
    logic                  mem_req_is_write;
    logic [DATA_W-1:0]     mem_req_addr;
    logic [DATA_W-1:0]     mem_req_data;
    logic                  mem_rsp_val;
    logic                  mem_rsp_rdy;
    logic [DATA_W-1:0]     mem_rsp_data;
    logic [2:0]            outstanding;
    logic                  err;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    falafel_mem_arbiter #(
        .DATA_W          (DATA_W),
        .NUM_REQ         (NUM_REQ),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_val_i          (req_val),
        .req_rdy_o          (req_rdy),
        .req_is_write_i     (req_is_write),
        .req_addr_i         (req_addr),
        .req_data_i         (req_data),
        .rsp_val_o          (rsp_val),
        .rsp_rdy_i          (rsp_rdy),
        .rsp_data_o         (rsp_data),
        .mem_req_val_o      (mem_req_val),
        .mem_req_rdy_i      (mem_req_rdy),
        .mem_req_is_write_o (mem_req_is_write),
        .mem_req_addr_o     (mem_req_addr),
        .mem_req_data_o     (mem_req_data),
        .mem_rsp_val_i      (mem_rsp_val),
        .mem_rsp_rdy_o      (mem_rsp_rdy),
        .mem_rsp_data_i     (mem_rsp_data),
        .outstanding_o      (outstanding),
        .err_o              (err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_val      = '0;
        req_is_write = '0;
        req_addr     = '0;
        req_data     = '0;
        rsp_rdy      = '0;
        mem_req_rdy  = 1'b0;
        mem_rsp_val  = 1'b0;
        mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Handshake outputs stay low while reset is held, even with live inputs.
        rst          = 1'b1;
        req_val      = 2'b11;
        req_addr     = {64'h200, 64'h100};
        mem_req_rdy  = 1'b1;
        mem_rsp_val  = 1'b1;
        rsp_rdy      = 2'b11;
        #2;
        compared++; if (mem_req_val !== 1'b0) begin mismatched++; $display("FAIL in_rst_mem_req_val: got %b want 0", mem_req_val); end
        compared++; if (req_rdy !== 2'b00) begin mismatched++; $display("FAIL in_rst_req_rdy: got %b want 00", req_rdy); end
        compared++; if (rsp_val !== 2'b00) begin mismatched++; $display("FAIL in_rst_rsp_val: got %b want 00", rsp_val); end
        compared++; if (mem_rsp_rdy !== 1'b0) begin mismatched++; $display("FAIL in_rst_mem_rsp_rdy: got %b want 0", mem_rsp_rdy); end
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        req_addr = {64'h200, 64'h100};
        #2;
        compared++; if (req_rdy !== 2'b00) begin mismatched++; $display("FAIL rst_req_rdy: got %b want 00", req_rdy); end
        compared++; if (rsp_val !== 2'b00) begin mismatched++; $display("FAIL rst_rsp_val: got %b want 00", rsp_val); end
        compared++; if (mem_req_val !== 1'b0) begin mismatched++; $display("FAIL rst_mem_req_val: got %b want 0", mem_req_val); end
        compared++; if (outstanding !== 3'd0) begin mismatched++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", err); end
        tick();
        // Both requesters valid: index 0 wins first.
        req_val     = 2'b11;
        mem_req_rdy = 1'b1;
        #2;
        compared++; if (req_rdy !== 2'b01) begin mismatched++; $display("FAIL rst_first_grant: got %b want 01", req_rdy); end
        compared++; if (mem_req_addr !== 64'h100) begin mismatched++; $display("FAIL rst_first_addr: got %h want 100", mem_req_addr); end
        tick();
        req_val = 2'b00;
        #2;
        compared++; if (outstanding !== 3'd1) begin mismatched++; $display("FAIL rst_outst_after_push: got %0d want 1", outstanding); end
        mem_rsp_val  = 1'b1;
        mem_rsp_data = 64'h99;
        rsp_rdy      = 2'b11;
        #1;
        compared++; if (rsp_val !== 2'b01) begin mismatched++; $display("FAIL rst_rsp_route: got %b want 01", rsp_val); end
        compared++; if (rsp_data !== 64'h99) begin mismatched++; $display("FAIL rst_rsp_data: got %h want 99", rsp_data); end
        tick();
        mem_rsp_val = 1'b0;
        #2;
        compared++; if (outstanding !== 3'd0) begin mismatched++; $display("FAIL rst_outst_after_pop: got %0d want 0", outstanding); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_grant [4];
        logic [63:0] exp_addr  [4];
        exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_addr  = '{64'h100, 64'h200, 64'h100, 64'h200};
        do_reset();
        req_addr    = {64'h200, 64'h100};
        mem_req_rdy = 1'b1;
        rsp_rdy     = 2'b11;
        // Responses trail requests by one cycle: push and pop overlap.
        for (int c = 0; c < 5; c++) begin
            req_val      = (c < 4) ? 2'b11 : 2'b00;
            mem_rsp_val  = (c >= 1);
            mem_rsp_data = 64'hA + 64'(c - 1);
            #2;
            if (c < 4) begin
                compared++; if (req_rdy !== exp_grant[c]) begin mismatched++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_rdy, exp_grant[c]); end
                compared++; if (mem_req_addr !== exp_addr[c]) begin mismatched++; $display("FAIL rr_addr[%0d]: got %h want %h", c, mem_req_addr, exp_addr[c]); end
            end
            if (c >= 1) begin
                compared++; if (rsp_val !== exp_grant[c-1]) begin mismatched++; $display("FAIL rr_rsp_route[%0d]: got %b want %b", c, rsp_val, exp_grant[c-1]); end
                compared++; if (rsp_data !== 64'hA + 64'(c - 1)) begin mismatched++; $display("FAIL rr_rsp_data[%0d]: got %h want %h", c, rsp_data, 64'hA + 64'(c - 1)); end
                compared++; if (outstanding !== 3'd1) begin mismatched++; $display("FAIL rr_outstanding[%0d]: got %0d want 1", c, outstanding); end
            end
            tick();
        end
        mem_rsp_val = 1'b0;
        #2;
        compared++; if (outstanding !== 3'd0) begin mismatched++; $display("FAIL rr_drained: got %0d want 0", outstanding); end
        tick();
    endtask

    task automatic test_lock();
        do_reset();
        req_is_write = 2'b01;
        req_addr     = {64'h200, 64'h40};
        req_data     = {64'h0, 64'h55};
        for (int c = 0; c < 5; c++) begin
            req_val     = (c == 0) ? 2'b01 : ((c <= 3) ? 2'b11 : 2'b10);
            mem_req_rdy = (c >= 3);
            #2;
            if (c <= 3) begin
                compared++; if (mem_req_addr !== 64'h40) begin mismatched++; $display("FAIL lock_addr[%0d]: got %h want 40", c, mem_req_addr); end
                compared++; if (mem_req_data !== 64'h55) begin mismatched++; $display("FAIL lock_data[%0d]: got %h want 55", c, mem_req_data); end
                compared++; if (mem_req_is_write !== 1'b1) begin mismatched++; $display("FAIL lock_is_write[%0d]: got %b want 1", c, mem_req_is_write); end
                compared++; if (mem_req_val !== 1'b1) begin mismatched++; $display("FAIL lock_val[%0d]: got %b want 1", c, mem_req_val); end
                compared++; if (req_rdy !== ((c == 3) ? 2'b01 : 2'b00)) begin mismatched++; $display("FAIL lock_rdy[%0d]: got %b want %b", c, req_rdy, (c == 3) ? 2'b01 : 2'b00); end
            end else begin
                compared++; if (req_rdy !== 2'b10) begin mismatched++; $display("FAIL lock_next_grant: got %b want 10", req_rdy); end
                compared++; if (mem_req_addr !== 64'h200) begin mismatched++; $display("FAIL lock_next_addr: got %h want 200", mem_req_addr); end
                compared++; if (mem_req_is_write !== 1'b0) begin mismatched++; $display("FAIL lock_next_is_write: got %b want 0", mem_req_is_write); end
            end
            tick();
        end
        req_val = 2'b00;
        #2;
        compared++; if (outstanding !== 3'd1) begin mismatched++; $display("FAIL lock_outstanding: got %0d want 1", outstanding); end
        tick();
    endtask

    task automatic test_fifo_full();
        do_reset();
        req_addr    = {64'h300, 64'h80};
        req_data    = {64'h0, 64'hDEAD};
        mem_req_rdy = 1'b1;
        rsp_rdy     = 2'b11;
        req_val     = 2'b10;
        for (int c = 0; c < 4; c++) begin
            #2;
            compared++; if (req_rdy !== 2'b10) begin mismatched++; $display("FAIL full_fill_rdy[%0d]: got %b want 10", c, req_rdy); end
            compared++; if (outstanding !== 3'(c)) begin mismatched++; $display("FAIL full_fill_outst[%0d]: got %0d want %0d", c, outstanding, c); end
            tick();
        end
        // FIFO full: the read stalls, the write from requester 0 goes through.
        req_val      = 2'b11;
        req_is_write = 2'b01;
        #2;
        compared++; if (req_rdy !== 2'b01) begin mismatched++; $display("FAIL full_write_rdy: got %b want 01", req_rdy); end
        compared++; if (mem_req_is_write !== 1'b1) begin mismatched++; $display("FAIL full_write_flag: got %b want 1", mem_req_is_write); end
        compared++; if (mem_req_addr !== 64'h80) begin mismatched++; $display("FAIL full_write_addr: got %h want 80", mem_req_addr); end
        compared++; if (outstanding !== 3'd4) begin mismatched++; $display("FAIL full_outst: got %0d want 4", outstanding); end
        tick();
        // A pop in this cycle must not admit the read yet.
        req_val      = 2'b10;
        mem_rsp_val  = 1'b1;
        mem_rsp_data = 64'h5A;
        #2;
        compared++; if (req_rdy !== 2'b00) begin mismatched++; $display("FAIL full_pop_cycle_rdy: got %b want 00", req_rdy); end
        compared++; if (mem_req_val !== 1'b0) begin mismatched++; $display("FAIL full_pop_cycle_val: got %b want 0", mem_req_val); end
        compared++; if (rsp_val !== 2'b10) begin mismatched++; $display("FAIL full_rsp_route: got %b want 10", rsp_val); end
        compared++; if (mem_rsp_rdy !== 1'b1) begin mismatched++; $display("FAIL full_mem_rsp_rdy: got %b want 1", mem_rsp_rdy); end
        tick();
        mem_rsp_val = 1'b0;
        #2;
        compared++; if (outstanding !== 3'd3) begin mismatched++; $display("FAIL full_after_pop_outst: got %0d want 3", outstanding); end
        compared++; if (req_rdy !== 2'b10) begin mismatched++; $display("FAIL full_read_admitted: got %b want 10", req_rdy); end
        tick();
        req_val = 2'b00;
        #2;
        compared++; if (outstanding !== 3'd4) begin mismatched++; $display("FAIL full_refilled: got %0d want 4", outstanding); end
        tick();
    endtask

    task automatic test_rsp_backpressure();
        do_reset();
        req_addr    = {64'h300, 64'h0};
        mem_req_rdy = 1'b1;
        req_val     = 2'b10;
        #2;
        compared++; if (req_rdy !== 2'b10) begin mismatched++; $display("FAIL bp_grant: got %b want 10", req_rdy); end
        tick();
        req_val      = 2'b00;
        mem_rsp_val  = 1'b1;
        mem_rsp_data = 64'h77;
        rsp_rdy      = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #2;
            compared++; if (mem_rsp_rdy !== 1'b0) begin mismatched++; $display("FAIL bp_mem_rsp_rdy[%0d]: got %b want 0", c, mem_rsp_rdy); end
            compared++; if (rsp_val !== 2'b10) begin mismatched++; $display("FAIL bp_rsp_val[%0d]: got %b want 10", c, rsp_val); end
            compared++; if (rsp_data !== 64'h77) begin mismatched++; $display("FAIL bp_rsp_data[%0d]: got %h want 77", c, rsp_data); end
            compared++; if (outstanding !== 3'd1) begin mismatched++; $display("FAIL bp_outst[%0d]: got %0d want 1", c, outstanding); end
            tick();
        end
        rsp_rdy = 2'b11;
        #2;
        compared++; if (mem_rsp_rdy !== 1'b1) begin mismatched++; $display("FAIL bp_release_rdy: got %b want 1", mem_rsp_rdy); end
        compared++; if (rsp_val !== 2'b10) begin mismatched++; $display("FAIL bp_release_val: got %b want 10", rsp_val); end
        tick();
        // FIFO now empty: a stray response is swallowed and flagged.
        mem_rsp_data = 64'hEE;
        #2;
        compared++; if (outstanding !== 3'd0) begin mismatched++; $display("FAIL stray_outst: got %0d want 0", outstanding); end
        compared++; if (rsp_val !== 2'b00) begin mismatched++; $display("FAIL stray_rsp_val: got %b want 00", rsp_val); end
        compared++; if (mem_rsp_rdy !== 1'b1) begin mismatched++; $display("FAIL stray_mem_rsp_rdy: got %b want 1", mem_rsp_rdy); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL stray_err_before: got %b want 0", err); end
        tick();
        mem_rsp_val = 1'b0;
        #2;
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL stray_err_set: got %b want 1", err); end
        tick();
        #2;
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL stray_err_sticky: got %b want 1", err); end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_addr    = {64'h200, 64'h100};
        mem_req_rdy = 1'b1;
        rsp_rdy     = 2'b11;
        req_val     = 2'b11;
        tick();
        tick();
        req_val = 2'b00;
        #2;
        compared++; if (outstanding !== 3'd2) begin mismatched++; $display("FAIL mid_outst_before: got %0d want 2", outstanding); end
        rst = 1'b1;
        #1;
        compared++; if (outstanding !== 3'd0) begin mismatched++; $display("FAIL mid_outst_in_rst: got %0d want 0", outstanding); end
        tick();
        rst          = 1'b0;
        mem_rsp_val  = 1'b1;
        mem_rsp_data = 64'h11;
        #2;
        compared++; if (rsp_val !== 2'b00) begin mismatched++; $display("FAIL mid_rsp_val: got %b want 00", rsp_val); end
        compared++; if (mem_rsp_rdy !== 1'b1) begin mismatched++; $display("FAIL mid_mem_rsp_rdy: got %b want 1", mem_rsp_rdy); end
        tick();
        mem_rsp_val = 1'b0;
        #2;
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL mid_err: got %b want 1", err); end
        compared++; if (rsp_val !== 2'b00) begin mismatched++; $display("FAIL mid_rsp_val_after: got %b want 00", rsp_val); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        tick();
        test_reset();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_rsp_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
